unary_stream_decoder: RTL and testbench
=======================================

# unary_stream_decoder

Receiving end for the serial unary bitstreams produced by the unary arithmetic units (e.g. the ×2 bounds unit). It accepts a `bit_in`/`bit_valid` stream and counts ones over a frame of `INPUT_WIDTH` accepted bits. It returns the binary value through a ready/valid output handshake. While a frame is in progress it publishes live lower/upper bounds and an early threshold decision, so downstream logic can act before the frame completes.

## Interface
- `INPUT_WIDTH`, 32, number of accepted bits per frame.
- `COUNT_WIDTH`, `$clog2(INPUT_WIDTH+1)`, width of all count/value outputs.
- `THRESHOLD`, `INPUT_WIDTH/2`, compare point for the early decision; legal range 0..INPUT_WIDTH.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `flush`  in  1  synchronous frame abort.
- `bit_in`  in  1  unary stream bit.
- `bit_valid`  in  1  `bit_in` is meaningful this cycle.
- `bit_ready`  out  1  decoder accepts a bit this cycle.
- `lower_bound`  out  COUNT_WIDTH  ones accepted so far in the current frame.
- `upper_bound`  out  COUNT_WIDTH  `INPUT_WIDTH - bits_accepted + ones`.
- `decided`  out  1  threshold outcome is known for this frame (sticky).
- `decision`  out  1  outcome: 1 = final value ≥ THRESHOLD. Meaningful only when `decided`=1.
- `value`  out  COUNT_WIDTH  final ones count of the completed frame.
- `value_valid`  out  1  `value` is held for consumption.
- `value_ready`  in  1  consumer takes `value`.

## Operation
- State register has two states, COLLECT and HOLD. `bit_ready` = (state==COLLECT), decoded from the registered state.
- A bit is accepted when `bit_valid && bit_ready`.

**COLLECT**
- Each accepted bit does `ones += bit_in` and `cnt += 1`.
- When the accepted bit is the INPUT_WIDTH-th bit (`cnt == INPUT_WIDTH-1` before the update):
  - `value <= ones + bit_in`, `value_valid <= 1`.
  - `decided <= 1`; `decision <= (ones + bit_in >= THRESHOLD)`.
  - state → HOLD.

**HOLD**
- No bits are accepted; `bit_valid` is ignored.
- When `value_ready`=1: `value_valid <= 0`, `ones`/`cnt`/`decided`/`decision` cleared, state → COLLECT.
- `value` retains its last value until overwritten by the next frame.

**Bounds and early decision**
- `lower_bound` and `upper_bound` are combinational from the registered `ones`/`cnt`, so they reflect bits accepted up to the previous edge.
- In COLLECT, when not already `decided`, the decision is registered on the edge that accepts the bit making it known:
  - `lower_bound ≥ THRESHOLD` → `decided <= 1`, `decision <= 1`.
  - `upper_bound < THRESHOLD` → `decided <= 1`, `decision <= 0`.
- Once set, `decided`/`decision` hold until the frame is consumed or flushed.
- THRESHOLD=0 sets `decided`=1, `decision`=1 on the first cycle in COLLECT.

**Arithmetic**
- `ones`, `cnt` and `value` are COUNT_WIDTH-bit unsigned and never exceed INPUT_WIDTH, so there is no wrap.
- `upper_bound` is computed at COUNT_WIDTH+1 bits internally and truncated; its range is 0..INPUT_WIDTH.

**Priority (highest first)**
1. reset
2. flush
3. frame completion / HOLD release
4. bit accept
- `flush` in any state clears `ones`, `cnt`, `decided`, `decision` and `value_valid`, and forces COLLECT. A bit presented in the same cycle is discarded. `value` is not cleared.

## Timing
- **Reset values:** state=COLLECT, so `bit_ready`=1. `lower_bound`=0, `upper_bound`=INPUT_WIDTH, `decided`=0, `decision`=0, `value`=0, `value_valid`=0.
- **Latency:** `value_valid` rises on the edge that accepts the final bit, so it is visible the cycle after the last `bit_valid`.
- **Handshake:**
  - `value_valid` stays high, and `value` stable, until the cycle `value_ready`=1; it deasserts on that edge.
  - `value_ready` asserted while `value_valid`=0 has no effect.
- **Throughput:** `bit_ready` returns the cycle after consumption, giving one bubble per frame. The minimum frame period is INPUT_WIDTH+1 cycles with `value_ready` tied high.
- **Gaps:** `bit_valid` gaps stall counting without affecting the frame.
- **Reset mid-frame:** all state returns to the reset values asynchronously; the partial frame is lost.

## Test plan
- **Reset values:** reset low, then release → `bit_ready`=1, `upper_bound`=32, all other outputs 0.
- **Full count with stall:** 32 consecutive ones, `value_ready`=0 → `value_valid`=1 the cycle after bit 32 with `value`=32 and `decision`=1. `decided` rose after bit 16. `bit_ready`=0 until `value_ready` is pulsed, then `bit_ready`=1 the next cycle.
- **Early zero decision:** alternating 0,1 starting with 0, `bit_valid` deasserted every third cycle → `decided`=1 (`decision`=0) only when `upper_bound` < 16. Final `value`=16 with `decision`=1, because the frame-completion rule overrides an undecided state. Bounds are checked after every accepted bit.
- **Early zero decision, all zeros:** 17 zeros → `decided`=1, `decision`=0 after bit 17; the frame completes with `value`=0.
- **Flush mid-frame:** `flush` after bit 10 with a 1 on `bit_in` the same cycle → `lower_bound`=0 and `upper_bound`=32 next cycle. The following 32-bit frame decodes independently.
- **Back-to-back frames:** two frames with `value_ready` tied high, values 5 then 31 → each `value_valid` is one cycle long, frames are separated by exactly one bubble, and both values are correct. Then assert reset during bit 20 of a third frame → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/unary_stream_decoder.sv
// unary_stream_decoder: counts ones over frames of INPUT_WIDTH accepted bits,
// publishes live lower/upper bounds and a sticky early threshold decision
// while a frame is in progress, and hands the final count to a consumer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: bit_valid/bit_ready, where bit_ready is decoded only
// from the registered state. Output side: value_valid/value_ready, where
// value_valid and value stay stable until that transfer edge. value_ready is
// ignored while value_valid is low.
module unary_stream_decoder #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
  parameter int THRESHOLD   = INPUT_WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
  output logic                   decided,
  output logic                   decision,
  output logic [COUNT_WIDTH-1:0] value,
  output logic                   value_valid,
  input  logic                   value_ready,
  output logic                   dbg_state_o
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Counts never exceed INPUT_WIDTH, so COUNT_WIDTH-bit modular arithmetic
  // gives exact bounds (W - cnt cannot underflow).
  localparam logic [COUNT_WIDTH-1:0] WIDTH_C = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] THR_C   = COUNT_WIDTH'(THRESHOLD);
  localparam logic [COUNT_WIDTH-1:0] LAST_C  = COUNT_WIDTH'(INPUT_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] ones_q, ones_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] value_q, value_d;
  logic                   value_valid_q, value_valid_d;
  logic                   decided_q, decided_d;
  logic                   decision_q, decision_d;

  logic                   accept;
  logic [COUNT_WIDTH-1:0] ones_inc;
  logic [COUNT_WIDTH-1:0] ones_nx;
  logic [COUNT_WIDTH-1:0] cnt_nx;
  logic [COUNT_WIDTH-1:0] ub_nx;

  assign bit_ready   = (state_q == COLLECT);
  assign accept      = bit_valid && bit_ready;
  assign ones_inc    = ones_q + {{(COUNT_WIDTH-1){1'b0}}, bit_in};

  // Post-accept counts: the early decision is taken on the same edge that
  // accepts the bit that makes the outcome certain.
  assign ones_nx     = accept ? ones_inc : ones_q;
  assign cnt_nx      = accept ? (cnt_q + 1'b1) : cnt_q;
  assign ub_nx       = WIDTH_C - cnt_nx + ones_nx;

  assign lower_bound = ones_q;
  assign upper_bound = WIDTH_C - cnt_q + ones_q;
  assign decided     = decided_q;
  assign decision    = decision_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign dbg_state_o = state_q;

  // Next-state logic: flush beats completion/release, which beats a plain accept.
  always_comb begin
    state_d       = state_q;
    ones_d        = ones_q;
    cnt_d         = cnt_q;
    value_d       = value_q;
    value_valid_d = value_valid_q;
    decided_d     = decided_q;
    decision_d    = decision_q;

    if (flush) begin
      ones_d        = '0;
      cnt_d         = '0;
      decided_d     = 1'b0;
      decision_d    = 1'b0;
      value_valid_d = 1'b0;
      state_d       = COLLECT;
    end else if (state_q == HOLD) begin
      if (value_ready) begin
        ones_d        = '0;
        cnt_d         = '0;
        decided_d     = 1'b0;
        decision_d    = 1'b0;
        value_valid_d = 1'b0;
        state_d       = COLLECT;
      end
    end else begin
      ones_d = ones_nx;
      cnt_d  = cnt_nx;
      if (!decided_q) begin
        if (ones_nx >= THR_C) begin
          decided_d  = 1'b1;
          decision_d = 1'b1;
        end else if (ub_nx < THR_C) begin
          decided_d  = 1'b1;
          decision_d = 1'b0;
        end
      end
      // Frame completion always fixes the outcome from the final count.
      if (accept && (cnt_q == LAST_C)) begin
        value_d       = ones_inc;
        value_valid_d = 1'b1;
        decided_d     = 1'b1;
        decision_d    = (ones_inc >= THR_C);
        state_d       = HOLD;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= COLLECT;
      ones_q        <= '0;
      cnt_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      decided_q     <= 1'b0;
      decision_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      decided_q     <= decided_d;
      decision_q    <= decision_d;
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed testbench for unary_stream_decoder (INPUT_WIDTH=32, THRESHOLD=16).
module tb_unary_stream_decoder;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [CW-1:0] lower_bound;
  logic [CW-1:0] upper_bound;
  logic          decided;
  logic          decision;
  logic [CW-1:0] value;
  logic          value_valid;
  logic          value_ready;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;

  unary_stream_decoder #(.INPUT_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
    .decided     (decided),
    .decision    (decision),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one edge and land 1ns after it for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; value_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({bit_ready, value_valid, decided, decision} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000", {bit_ready, value_valid, decided, decision});
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bit_ready, value_valid, decided, decision} !== 4'b1000) begin
      errors++; $display("FAIL post_reset_flags: got %b expected 1000", {bit_ready, value_valid, decided, decision});
    end
    checks++;
    if (lower_bound !== 6'd0 || upper_bound !== 6'd32 || value !== 6'd0) begin
      errors++; $display("FAIL post_reset_values: got lb=%0d ub=%0d val=%0d expected 0 32 0", lower_bound, upper_bound, value);
    end
  endtask

  task automatic test_full_count();
    value_ready = 1'b0;
    for (int k = 1; k <= W; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
      checks++;
      if (lower_bound !== CW'(k) || upper_bound !== 6'd32) begin
        errors++; $display("FAIL full_bounds bit %0d: got lb=%0d ub=%0d expected %0d 32", k, lower_bound, upper_bound, k);
      end
      checks++;
      if (decided !== (k >= 16) || (k >= 16 && decision !== 1'b1)) begin
        errors++; $display("FAIL full_decided bit %0d: got decided=%b decision=%b expected decided=%b", k, decided, decision, (k >= 16));
      end
    end
    checks++;
    if ({bit_ready, value_valid, decided, decision} !== 4'b0111 || value !== 6'd32) begin
      errors++; $display("FAIL full_done: got flags=%b val=%0d expected 0111 32", {bit_ready, value_valid, decided, decision}, value);
    end
    // Stall in HOLD with bit_valid still high: nothing may change.
    repeat (3) step();
    checks++;
    if ({bit_ready, value_valid} !== 2'b01 || value !== 6'd32 || lower_bound !== 6'd32) begin
      errors++; $display("FAIL full_stall: got rdy=%b vv=%b val=%0d lb=%0d expected 0 1 32 32", bit_ready, value_valid, value, lower_bound);
    end
    bit_valid = 1'b0;
    value_ready = 1'b1;
    step();
    value_ready = 1'b0;
    checks++;
    if ({bit_ready, value_valid, decided, decision} !== 4'b1000 || value !== 6'd32 || lower_bound !== 6'd0) begin
      errors++; $display("FAIL full_consume: got flags=%b val=%0d lb=%0d expected 1000 32 0", {bit_ready, value_valid, decided, decision}, value, lower_bound);
    end
  endtask

  task automatic test_all_zeros();
    for (int k = 1; k <= W; k++) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      step();
      checks++;
      if (lower_bound !== 6'd0 || upper_bound !== CW'(W - k)) begin
        errors++; $display("FAIL zeros_bounds bit %0d: got lb=%0d ub=%0d expected 0 %0d", k, lower_bound, upper_bound, W - k);
      end
      checks++;
      if (decided !== (k >= 17) || decision !== 1'b0) begin
        errors++; $display("FAIL zeros_decided bit %0d: got decided=%b decision=%b expected %b 0", k, decided, decision, (k >= 17));
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (value_valid !== 1'b1 || value !== 6'd0) begin
      errors++; $display("FAIL zeros_done: got vv=%b val=%0d expected 1 0", value_valid, value);
    end
    value_ready = 1'b1;
    step();
    value_ready = 1'b0;
  endtask

  task automatic test_early_zero();
    int n = 0;
    for (int c = 0; c < 100 && n < W; c++) begin
      bit_valid = (c % 3 != 2);
      bit_in = n[0];
      step();
      if (bit_valid) n++;
      checks++;
      if (lower_bound !== CW'(n / 2) || upper_bound !== CW'(W - n + n / 2)) begin
        errors++; $display("FAIL alt_bounds n=%0d: got lb=%0d ub=%0d expected %0d %0d", n, lower_bound, upper_bound, n / 2, W - n + n / 2);
      end
      checks++;
      if (n < W && decided !== 1'b0) begin
        errors++; $display("FAIL alt_undecided n=%0d: got decided=%b expected 0", n, decided);
      end
    end
    bit_valid = 1'b0;
    checks++;
    if ({value_valid, decided, decision} !== 3'b111 || value !== 6'd16) begin
      errors++; $display("FAIL alt_done: got flags=%b val=%0d expected 111 16", {value_valid, decided, decision}, value);
    end
    value_ready = 1'b1;
    step();
    value_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 10; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
    end
    checks++;
    if (lower_bound !== 6'd10) begin
      errors++; $display("FAIL flush_pre: got lb=%0d expected 10", lower_bound);
    end
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    step();
    flush = 1'b0; bit_valid = 1'b0;
    checks++;
    if (lower_bound !== 6'd0 || upper_bound !== 6'd32 || value !== 6'd16) begin
      errors++; $display("FAIL flush_clear: got lb=%0d ub=%0d val=%0d expected 0 32 16", lower_bound, upper_bound, value);
    end
    checks++;
    if ({bit_ready, value_valid, decided, decision} !== 4'b1000) begin
      errors++; $display("FAIL flush_flags: got %b expected 1000", {bit_ready, value_valid, decided, decision});
    end
    // Next frame: 7 ones then zeros; upper bound drops below 16 at bit 24.
    for (int k = 1; k <= W; k++) begin
      bit_valid = 1'b1; bit_in = (k <= 7);
      step();
      checks++;
      if (decided !== (k >= 24) || decision !== 1'b0) begin
        errors++; $display("FAIL flush_frame bit %0d: got decided=%b decision=%b expected %b 0", k, decided, decision, (k >= 24));
      end
    end
    bit_valid = 1'b0;
    checks++;
    if (value_valid !== 1'b1 || value !== 6'd7) begin
      errors++; $display("FAIL flush_frame_done: got vv=%b val=%0d expected 1 7", value_valid, value);
    end
    value_ready = 1'b1;
    step();
    value_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    value_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      int ones_n = (f == 0) ? 5 : 31;
      for (int k = 0; k < W; k++) begin
        checks++;
        if (bit_ready !== 1'b1 || value_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_stream f%0d bit %0d: got rdy=%b vv=%b expected 1 0", f, k, bit_ready, value_valid);
        end
        bit_valid = 1'b1; bit_in = (k < ones_n);
        step();
      end
      checks++;
      if ({bit_ready, value_valid, decided} !== 3'b011 || value !== CW'(ones_n) || decision !== (ones_n >= 16)) begin
        errors++; $display("FAIL b2b_done f%0d: got rdy=%b vv=%b dec=%b val=%0d expected 0 1 %b %0d", f, bit_ready, value_valid, decision, value, (ones_n >= 16), ones_n);
      end
      bit_in = 1'b1;
      step();
      checks++;
      if ({bit_ready, value_valid} !== 2'b10 || lower_bound !== 6'd0) begin
        errors++; $display("FAIL b2b_bubble f%0d: got rdy=%b vv=%b lb=%0d expected 1 0 0", f, bit_ready, value_valid, lower_bound);
      end
    end
    // Third frame, reset asserted while bit 20 is on the wire.
    for (int k = 1; k <= 19; k++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
    end
    checks++;
    if (lower_bound !== 6'd19) begin
      errors++; $display("FAIL b2b_third_pre: got lb=%0d expected 19", lower_bound);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bit_ready, value_valid, decided, decision} !== 4'b1000) begin
      errors++; $display("FAIL async_reset_flags: got %b expected 1000", {bit_ready, value_valid, decided, decision});
    end
    checks++;
    if (lower_bound !== 6'd0 || upper_bound !== 6'd32 || value !== 6'd0) begin
      errors++; $display("FAIL async_reset_values: got lb=%0d ub=%0d val=%0d expected 0 32 0", lower_bound, upper_bound, value);
    end
    bit_valid = 1'b0; value_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (bit_ready !== 1'b1 || lower_bound !== 6'd0) begin
      errors++; $display("FAIL post_async_release: got rdy=%b lb=%0d expected 1 0", bit_ready, lower_bound);
    end
  endtask

  initial begin
    test_reset();
    test_full_count();
    test_all_zeros();
    test_early_zero();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
